melody_sequencer: RTL and testbench

//  Parametrised multi-voice step sequencer; successor to single-voice gate/pitch loopers.

---
 rtl/melody_sequencer_pkg.sv | 11 +
 rtl/melody_sequencer_voice.sv | 49 ++++
 rtl/melody_sequencer.sv | 89 ++++++++
 tb/tb_melody_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/melody_sequencer_pkg.sv
// melody_sequencer_pkg: default sizing and width helpers for the melody step sequencer.
package melody_sequencer_pkg;
    localparam int STEPS_DEF    = 16;
    localparam int VOICES_DEF   = 2;
    localparam int DEG_W_DEF    = 4;
    localparam int STEP_DIV_DEF = 524288;

    function automatic int vw_of(input int voices);
        return (voices > 1) ? $clog2(voices) : 1;
    endfunction
endpackage

// File: rtl/melody_sequencer_voice.sv
// melody_sequencer_voice: one voice's gate/degree step memory with write port and
// registered read of the step that will be current after this edge.
module melody_sequencer_voice
    import melody_sequencer_pkg::*;
#(
    parameter int STEPS = STEPS_DEF,
    parameter int DEG_W = DEG_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sel,
    input  logic                       set,
    input  logic                       clear,
    input  logic                       deg_wr,
    input  logic [DEG_W-1:0]           deg_in,
    input  logic [$clog2(STEPS)-1:0]   wr_idx,
    input  logic [$clog2(STEPS)-1:0]   rd_idx,
    output logic                       rd_gate,
    output logic                       gate,
    output logic [DEG_W-1:0]           degree
);
    logic [STEPS-1:0] mem_gate;
    logic [DEG_W-1:0] mem_deg [STEPS];
    logic             wr_g, wr_d, hit;
    logic [DEG_W-1:0] rd_deg;

    // Bypass so a write to the step being read shows up on the next cycle.
    always_comb begin
        wr_g    = sel & (set | clear);
        wr_d    = sel & deg_wr;
        hit     = wr_idx == rd_idx;
        rd_gate = (wr_g && hit) ? !clear : mem_gate[rd_idx];
        rd_deg  = (wr_d && hit) ? deg_in : mem_deg[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_gate <= '0;
            for (int i = 0; i < STEPS; i++) mem_deg[i] <= '0;
            gate     <= 1'b0;
            degree   <= '0;
        end else begin
            if (wr_g) mem_gate[wr_idx] <= !clear;
            if (wr_d) mem_deg[wr_idx] <= deg_in;
            gate   <= rd_gate;
            degree <= rd_deg;
        end
    end
endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: multi-voice step sequencer with step divider, runtime loop length and note_on.
// Define MELODY_SEQ_SHORT_GATE_EN for staccato gates (high only in the first half of each step).
module melody_sequencer
    import melody_sequencer_pkg::*;
#(
    parameter int STEPS    = STEPS_DEF,
    parameter int VOICES   = VOICES_DEF,
    parameter int DEG_W    = DEG_W_DEF,
    parameter int STEP_DIV = STEP_DIV_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [$clog2(STEPS):0]     loop_len,
    input  logic [vw_of(VOICES)-1:0]   voice_sel,
    input  logic                       set,
    input  logic                       clear,
    input  logic                       deg_wr,
    input  logic [DEG_W-1:0]           deg_in,
    output logic [$clog2(STEPS)-1:0]   step_idx,
    output logic                       step_tick,
    output logic [VOICES-1:0]          gate,
    output logic [VOICES*DEG_W-1:0]    degree,
    output logic [VOICES-1:0]          note_on
);
    localparam int SW = $clog2(STEPS);
    localparam int VW = vw_of(VOICES);
    localparam int DW = $clog2(STEP_DIV);

    logic [DW-1:0]     div_cnt, div_nxt;
    logic [SW:0]       eff_len, step_inc;
    logic [SW-1:0]     step_nxt, rd_idx;
    logic              adv;
    logic [VOICES-1:0] rd_gate, gate_q;

    // A shortened loop only takes effect at the next advance, never mid-step.
    always_comb begin
        adv      = run && div_cnt == DW'(STEP_DIV - 1);
        div_nxt  = !run ? div_cnt : adv ? '0 : div_cnt + 1'b1;
        eff_len  = (loop_len == '0 || loop_len > (SW+1)'(STEPS)) ? (SW+1)'(STEPS) : loop_len;
        step_inc = {1'b0, step_idx} + 1'b1;
        step_nxt = (step_inc >= eff_len) ? '0 : step_inc[SW-1:0];
        rd_idx   = adv ? step_nxt : step_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            step_idx  <= '0;
            step_tick <= 1'b0;
            note_on   <= '0;
        end else begin
            div_cnt   <= div_nxt;
            if (adv) step_idx <= step_nxt;
            step_tick <= adv;
            note_on   <= adv ? rd_gate : '0;
        end
    end

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        melody_sequencer_voice #(.STEPS(STEPS), .DEG_W(DEG_W)) u_voice (
            .clk     (clk),
            .rst     (rst),
            .sel     (voice_sel == VW'(v)),
            .set     (set),
            .clear   (clear),
            .deg_wr  (deg_wr),
            .deg_in  (deg_in),
            .wr_idx  (step_idx),
            .rd_idx  (rd_idx),
            .rd_gate (rd_gate[v]),
            .gate    (gate_q[v]),
            .degree  (degree[v*DEG_W +: DEG_W])
        );
    end

`ifdef MELODY_SEQ_SHORT_GATE_EN
    logic first_half;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) first_half <= 1'b1;
        else first_half <= div_nxt < DW'(STEP_DIV / 2);
    end

    assign gate = gate_q & {VOICES{first_half}};
`else
    assign gate = gate_q;
`endif
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: table-driven and hand-sequenced checks against a step-level reference model.
module tb_melody_sequencer;
    logic       clk = 1'b0, rst = 1'b1, run = 1'b0, set = 1'b0, clear = 1'b0, deg_wr = 1'b0;
    logic [3:0] loop_len = 4'd0, deg_in = 4'd0;
    logic [0:0] voice_sel = 1'b0;
    logic [2:0] step_idx;
    logic       step_tick;
    logic [1:0] gate, note_on;
    logic [7:0] degree;

    melody_sequencer #(.STEPS(8), .VOICES(2), .DEG_W(4), .STEP_DIV(4)) dut (
        .clk(clk), .rst(rst), .run(run), .loop_len(loop_len), .voice_sel(voice_sel),
        .set(set), .clear(clear), .deg_wr(deg_wr), .deg_in(deg_in),
        .step_idx(step_idx), .step_tick(step_tick), .gate(gate), .degree(degree), .note_on(note_on)
    );

    always #5 clk = ~clk;

    typedef struct packed {logic run; logic [3:0] len; logic vs, set, clr, dw; logic [3:0] din;} stim_t;
    typedef struct {stim_t s; int n;} seg_t;
    typedef struct packed {logic [2:0] step; logic tick; logic [1:0] gate; logic [7:0] deg; logic [1:0] note;} out_t;

    int         checks = 0, errors = 0;
    out_t       exp_q[$];
    int         m_div, m_step;
    bit         m_gate [2][8];
    logic [3:0] m_deg [2][8];
    logic [3:0] cur_len = 4'd0;

    function automatic stim_t mk(input logic r, input logic [3:0] l, input logic vs, input logic st,
                                 input logic cl, input logic dw, input logic [3:0] d);
        return {r, l, vs, st, cl, dw, d};
    endfunction

    function automatic out_t dut_out();
        return {step_idx, step_tick, gate, degree, note_on};
    endfunction

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_div = 0;
        m_step = 0;
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < 8; i++) begin
                m_gate[v][i] = 1'b0;
                m_deg[v][i] = 4'd0;
            end
        exp_q.delete();
    endtask

    // Expected outputs after the edge that consumes stimulus s.
    task automatic model(input stim_t s);
        int   eff, nxt;
        bit   adv;
        out_t e;
        eff = (s.len == 4'd0 || s.len > 4'd8) ? 8 : int'(s.len);
        adv = s.run && m_div == 3;
        nxt = adv ? ((m_step + 1 >= eff) ? 0 : m_step + 1) : m_step;
        if (s.set || s.clr) m_gate[s.vs][m_step] = !s.clr;
        if (s.dw) m_deg[s.vs][m_step] = s.din;
        if (s.run) m_div = (m_div + 1) % 4;
        m_step = nxt;
        e.step = 3'(m_step);
        e.tick = adv;
        for (int v = 0; v < 2; v++) begin
            e.gate[v] = m_gate[v][m_step];
            e.note[v] = adv && m_gate[v][m_step];
            e.deg[v*4 +: 4] = m_deg[v][m_step];
`ifdef MELODY_SEQ_SHORT_GATE_EN
            if (m_div >= 2) e.gate[v] = 1'b0;
`endif
        end
        exp_q.push_back(e);
    endtask

    task automatic cyc(input stim_t s);
        out_t e;
        {run, loop_len, voice_sel, set, clear, deg_wr, deg_in} = {s.run, s.len, s.vs, s.set, s.clr, s.dw, s.din};
        model(s);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("cycle", dut_out(), e);
    endtask

    task automatic idle();
        cyc(mk(1'b1, cur_len, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
    endtask

    task automatic run_until(input int target, input int budget, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            idle();
            hit = step_tick && step_idx == 3'(target);
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: step %0d not reached in %0d cycles, at step %0d", name, target, budget, step_idx);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        {run, loop_len, voice_sel, set, clear, deg_wr, deg_in} = '0;
        model_reset();
        @(posedge clk);
        #1;
        chk("reset", dut_out(), 16'h0);
        rst = 1'b0;
    endtask

    initial begin
        seg_t tbl[9];
        int   cnt;
        tbl[0] = '{mk(1'b1, 4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0), 6};
        tbl[1] = '{mk(1'b1, 4'd8,  1'b0, 1'b1, 1'b0, 1'b0, 4'd0), 5};
        tbl[2] = '{mk(1'b1, 4'd8,  1'b1, 1'b0, 1'b0, 1'b1, 4'd9), 3};
        tbl[3] = '{mk(1'b0, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0), 3};
        tbl[4] = '{mk(1'b1, 4'd8,  1'b0, 1'b0, 1'b1, 1'b1, 4'd3), 2};
        tbl[5] = '{mk(1'b1, 4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 4'd0), 24};
        tbl[6] = '{mk(1'b1, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0), 16};
        tbl[7] = '{mk(1'b1, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0, 4'd0), 8};
        tbl[8] = '{mk(1'b1, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0, 4'd0), 8};

        do_reset();
        foreach (tbl[i])
            for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].s);

        do_reset();
        cur_len = 4'd0;
        repeat (3) idle();
        idle();
        chk("first_tick", {step_idx, step_tick}, {3'd1, 1'b1});

        run_until(3, 8, "to_step3");
        cyc(mk(1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0));
        chk("set_visible", {gate, note_on}, 4'b1000);
        run_until(3, 40, "pass2_step3");
        chk("note_on_v1", {gate, note_on}, 4'b1010);

        run_until(2, 40, "to_step2");
        cyc(mk(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5));
        chk("deg_visible", degree, 8'h05);
        run_until(3, 8, "deg_step3");
        chk("deg_step3", degree, 8'h00);
        run_until(2, 40, "deg_step2");
        chk("deg_step2", degree, 8'h05);

        run_until(5, 40, "to_step5");
        repeat (3) idle();
        cyc(mk(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0));
        chk("adv_write", {step_idx, gate[0]}, {3'd6, 1'b0});
        run_until(5, 40, "pass_step5");
        chk("adv_landed", {gate, note_on}, 4'b0101);
        cnt = int'(gate[0]);
        repeat (3) begin
            idle();
            cnt += int'(gate[0]);
        end
`ifdef MELODY_SEQ_SHORT_GATE_EN
        chk("gate_len", 16'(cnt), 16'd2);
`else
        chk("gate_len", 16'(cnt), 16'd4);
`endif

        run_until(3, 40, "sc_step3");
        cyc(mk(1'b1, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0));
        chk("set_clear", gate, 2'b00);

        cur_len = 4'd3;
        run_until(0, 24, "len3_wrap");
        run_until(1, 4, "len3_1");
        run_until(2, 4, "len3_2");
        run_until(0, 4, "len3_0");
        run_until(2, 8, "len3_2b");
        cur_len = 4'd2;
        run_until(0, 4, "len2_wrap");
        cur_len = 4'd0;
        run_until(7, 28, "len0_7");
        run_until(0, 4, "len0_wrap");

        repeat (10) cyc(mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0));
        chk("hold", {step_idx, step_tick, note_on}, 6'b0);

        run_until(5, 24, "rst_step5");
        idle();
        chk("pre_rst_gate", gate[0], 1'b1);
        #2 rst = 1'b1;
        #1 chk("async_rst", dut_out(), 16'h0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
